// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one handshake memory bus between the fetch port and the data port
//   clk, rst                 : clock, asynchronous active-high reset
//   flush_i                  : cancels a pending fetch result
//   inst_* / stallreq_inst_o : fetch port and its stall request
//   data_* / stallreq_data_o : data port and its stall request (data has priority)
//   bus_*                    : external bus request/ack handshake
//   MEM_BUS_TIMEOUT_EN       : adds wait counter and bus_err_o timeout pulse
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              inst_ce_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_data_o,
  output logic              stallreq_inst_o,
  input  logic              data_ce_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_sel_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              stallreq_data_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i
`ifdef MEM_BUS_TIMEOUT_EN
  ,
  output logic              bus_err_o
`endif
);
  typedef enum logic [2:0] {IDLE, BUSY_D, BUSY_I, DONE_D, DONE_I} state_t;
  state_t state_q, state_d;
  logic drop_q, drop_d, we_q, we_d, busy, timeout, done, drop;
  logic [3:0] sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, drdata_q, drdata_d, irdata_q, irdata_d, rdata_in;
  assign busy = (state_q == BUSY_D) || (state_q == BUSY_I);
`ifdef MEM_BUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d     = busy ? cnt_q + 8'd1 : 8'd0;
  assign timeout   = busy && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign bus_err_o = timeout & ~bus_ack_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign timeout = 1'b0;
`endif
  assign done     = busy & (bus_ack_i | timeout);
  assign rdata_in = bus_ack_i ? bus_rdata_i : '0;
  // a flush arriving in the ack cycle itself still cancels the fetch result
  assign drop     = drop_q | flush_i;
  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    addr_d   = addr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    drdata_d = drdata_q;
    irdata_d = irdata_q;
    case (state_q)
      IDLE: begin
        if (data_ce_i) begin
          state_d = BUSY_D;
          addr_d  = data_addr_i;
          we_d    = data_we_i;
          sel_d   = data_sel_i;
          wdata_d = data_wdata_i;
        end else if (inst_ce_i) begin
          state_d = BUSY_I;
          addr_d  = inst_addr_i;
          we_d    = 1'b0;
          sel_d   = 4'b1111;
          wdata_d = '0;
        end
      end
      BUSY_D: begin
        state_d  = done ? DONE_D : BUSY_D;
        drdata_d = done ? (we_q ? '0 : rdata_in) : drdata_q;
      end
      BUSY_I: begin
        state_d  = done ? (drop ? IDLE : DONE_I) : BUSY_I;
        irdata_d = (done && !drop) ? rdata_in : irdata_q;
        drop_d   = done ? 1'b0 : drop;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      drop_q   <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      wdata_q  <= '0;
      drdata_q <= '0;
      irdata_q <= '0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      drdata_q <= drdata_d;
      irdata_q <= irdata_d;
    end
  assign bus_req_o       = busy;
  assign bus_we_o        = we_q;
  assign bus_sel_o       = sel_q;
  assign bus_addr_o      = addr_q;
  assign bus_wdata_o     = wdata_q;
  assign data_rdata_o    = drdata_q;
  assign inst_data_o     = irdata_q;
  assign stallreq_data_o = data_ce_i & (state_q != DONE_D);
  assign stallreq_inst_o = inst_ce_i & (state_q != DONE_I);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table-driven plus scoreboard checks of mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic clk = 0, rst = 1, flush_i = 0;
  logic inst_ce_i = 0, data_ce_i = 0, data_we_i = 0, bus_ack_i = 0;
  logic [31:0] inst_addr_i = 0, data_addr_i = 0, data_wdata_i = 0, bus_rdata_i = 0;
  logic [3:0] data_sel_i = 0;
  logic [31:0] inst_data_o, data_rdata_o, bus_addr_o, bus_wdata_o;
  logic stallreq_inst_o, stallreq_data_o, bus_req_o, bus_we_o;
  logic [3:0] bus_sel_o;
`ifdef MEM_BUS_TIMEOUT_EN
  logic bus_err_o;
`endif
  mem_bus_arbiter dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o),
    .stallreq_inst_o(stallreq_inst_o),
    .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
    .stallreq_data_o(stallreq_data_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
`ifdef MEM_BUS_TIMEOUT_EN
    , .bus_err_o(bus_err_o)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[5];
  logic [31:0] exp_q[$];
  logic [31:0] last_i = 0, last_d = 0;
  int n_cmp = 0, n_err = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pop_chk(string name, logic [31:0] act);
    if (exp_q.size() == 0) chk({name, "_sb_empty"}, 32'd1, 32'd0);
    else chk(name, act, exp_q.pop_front());
  endtask
  task automatic run(vec_t v);
    exp_q.push_back(v.exp);
    data_ce_i = v.is_d;
    inst_ce_i = !v.is_d;
    data_we_i = v.we;
    data_sel_i = v.sel;
    data_addr_i = v.addr;
    data_wdata_i = v.wdata;
    inst_addr_i = v.addr;
    #1;
    chk("idle_req", {31'd0, bus_req_o}, 0);
    chk("idle_stall", {31'd0, v.is_d ? stallreq_data_o : stallreq_inst_o}, 1);
    tick();
    for (int k = 0; k <= v.dly; k++) begin
      data_addr_i = $urandom;
      data_wdata_i = $urandom;
      data_sel_i = 4'($urandom);
      data_we_i = ~v.we;
      inst_addr_i = $urandom;
      bus_ack_i = (k == v.dly);
      bus_rdata_i = bus_ack_i ? v.rdata : $urandom;
      #1;
      chk("busy_req", {31'd0, bus_req_o}, 1);
      chk("busy_addr", bus_addr_o, v.addr);
      chk("busy_we", {31'd0, bus_we_o}, {31'd0, v.is_d & v.we});
      chk("busy_sel", {28'd0, bus_sel_o}, {28'd0, v.is_d ? v.sel : 4'b1111});
      if (v.is_d) chk("busy_wdata", bus_wdata_o, v.wdata);
      chk("busy_stall", {31'd0, v.is_d ? stallreq_data_o : stallreq_inst_o}, 1);
      tick();
    end
    bus_ack_i = 0;
    #1;
    chk("done_req", {31'd0, bus_req_o}, 0);
    chk("done_stall", {31'd0, v.is_d ? stallreq_data_o : stallreq_inst_o}, 0);
    if (v.is_d) begin
      pop_chk("data_rdata", data_rdata_o);
      chk("inst_keep", inst_data_o, last_i);
      last_d = v.exp;
    end else begin
      pop_chk("inst_data", inst_data_o);
      chk("data_keep", data_rdata_o, last_d);
      last_i = v.exp;
    end
    data_ce_i = 0;
    inst_ce_i = 0;
    tick();
  endtask
  initial begin
    vecs[0] = '{1, 0, 4'b1111, 32'h10,  32'h0,    32'hDEADBEEF, 1, 32'hDEADBEEF};
    vecs[1] = '{1, 1, 4'b0011, 32'h200, 32'h1234, 32'h55555555, 0, 32'h0};
    vecs[2] = '{0, 0, 4'b0000, 32'h100, 32'h0,    32'h0BADF00D, 0, 32'h0BADF00D};
    vecs[3] = '{0, 0, 4'b0000, 32'h104, 32'h0,    32'h11112222, 3, 32'h11112222};
    vecs[4] = '{1, 0, 4'b0100, 32'h300, 32'h0,    32'hA5A5A5A5, 5, 32'hA5A5A5A5};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, bus_req_o}, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_rdata", data_rdata_o, 0);
    chk("rst_inst", inst_data_o, 0);
    rst = 0;
    tick();
    foreach (vecs[i]) run(vecs[i]);
    // simultaneous requests: data write wins, fetch follows after IDLE
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h77);
    inst_ce_i = 1; inst_addr_i = 32'h100;
    data_ce_i = 1; data_we_i = 1; data_sel_i = 4'b0011;
    data_addr_i = 32'h200; data_wdata_i = 32'h1234;
    tick();
    bus_ack_i = 1; bus_rdata_i = 32'h99;
    #1;
    chk("sim_d_addr", bus_addr_o, 32'h200);
    chk("sim_d_we", {31'd0, bus_we_o}, 1);
    chk("sim_d_sel", {28'd0, bus_sel_o}, 32'h3);
    tick();
    bus_ack_i = 0;
    #1;
    chk("sim_d_stall", {31'd0, stallreq_data_o}, 0);
    chk("sim_i_stall1", {31'd0, stallreq_inst_o}, 1);
    pop_chk("sim_d_rdata", data_rdata_o);
    last_d = 0;
    data_ce_i = 0;
    tick();
    chk("sim_idle_req", {31'd0, bus_req_o}, 0);
    chk("sim_i_stall2", {31'd0, stallreq_inst_o}, 1);
    tick();
    bus_ack_i = 1; bus_rdata_i = 32'h77;
    #1;
    chk("sim_i_addr", bus_addr_o, 32'h100);
    chk("sim_i_sel", {28'd0, bus_sel_o}, 32'hF);
    chk("sim_i_stall3", {31'd0, stallreq_inst_o}, 1);
    tick();
    bus_ack_i = 0;
    #1;
    chk("sim_i_stall4", {31'd0, stallreq_inst_o}, 0);
    pop_chk("sim_i_data", inst_data_o);
    last_i = 32'h77;
    inst_ce_i = 0;
    tick();
    // flush during a pending fetch drops the result and skips DONE_I
    inst_ce_i = 1; inst_addr_i = 32'h400;
    tick();
    flush_i = 1;
    #1;
    chk("fl_req", {31'd0, bus_req_o}, 1);
    tick();
    flush_i = 0; bus_ack_i = 1; bus_rdata_i = 32'hCAFE0000;
    tick();
    bus_ack_i = 0;
    #1;
    chk("fl_inst", inst_data_o, last_i);
    chk("fl_stall", {31'd0, stallreq_inst_o}, 1);
    chk("fl_req2", {31'd0, bus_req_o}, 0);
    inst_ce_i = 0;
    tick();
    // asynchronous reset in the middle of a data access, then a stray ack
    data_ce_i = 1; data_we_i = 1; data_sel_i = 4'b1010;
    data_addr_i = 32'h500; data_wdata_i = 32'h5678;
    tick();
    #1;
    chk("mid_req", {31'd0, bus_req_o}, 1);
    rst = 1; data_ce_i = 0;
    #1;
    chk("ar_req", {31'd0, bus_req_o}, 0);
    chk("ar_addr", bus_addr_o, 0);
    chk("ar_we", {31'd0, bus_we_o}, 0);
    chk("ar_sel", {28'd0, bus_sel_o}, 0);
    chk("ar_wdata", bus_wdata_o, 0);
    chk("ar_rdata", data_rdata_o, 0);
    chk("ar_inst", inst_data_o, 0);
    chk("ar_stall", {30'd0, stallreq_data_o, stallreq_inst_o}, 0);
    tick();
    rst = 0;
    tick();
    bus_ack_i = 1; bus_rdata_i = 32'hFFFFFFFF;
    tick();
    bus_ack_i = 0;
    #1;
    chk("stray_req", {31'd0, bus_req_o}, 0);
    chk("stray_rdata", data_rdata_o, 0);
    tick();
    chk("stray_req2", {31'd0, bus_req_o}, 0);
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
